// File: rtl/mem_word_master.sv
// mem_word_master: turns one byte/halfword/word request into a sequence of
// single-byte accesses on a byte-wide RAM port, assembling read data
// little-endian. Optional busy-wait timeout is compiled in with MEM_TIMEOUT_EN.
module mem_word_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int BUS_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     reqWrite,
    input  logic [1:0]               reqSize,
    input  logic [ADDRESS_WIDTH-1:0] reqAddr,
    input  logic [31:0]              reqData,
    output logic                     ready,
    output logic                     done,
    output logic [31:0]              rdata,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] ramAddr,
    output logic [BUS_WIDTH-1:0]     ramDataOut,
    output logic                     ramWriteEnable,
    input  logic [BUS_WIDTH-1:0]     ramDataIn,
    input  logic                     ramBusy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [1:0]               size_q, size_d;
    logic                     write_q, write_d;
    logic [1:0]               idx_q, idx_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [BUS_WIDTH-1:0]     ram_dout_q, ram_dout_d;
    logic                     ram_we_q, ram_we_d;
    logic [1:0]               last_idx;
    logic [4:0]               lane_lsb;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     error_q, error_d;
`endif

    // Index of the final byte: 0 for byte, 1 for halfword, 3 for word (size 2 or 3).
    assign last_idx = (size_q == 2'd0) ? 2'd0 : (size_q == 2'd1) ? 2'd1 : 2'd3;
    assign lane_lsb = {idx_q, 3'b000};

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        write_d    = write_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        ram_we_d   = ram_we_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = reqAddr;
                    wdata_d = reqData;
                    size_d  = reqSize;
                    write_d = reqWrite;
                    idx_d   = 2'd0;
                    if (!reqWrite) rdata_d = 32'h0;
`ifdef MEM_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Address arithmetic wraps naturally at the top of the space.
                ram_addr_d = addr_q + ADDRESS_WIDTH'(idx_q);
                ram_dout_d = wdata_q[lane_lsb +: 8];
                ram_we_d   = write_q;
`ifdef MEM_TIMEOUT_EN
                cnt_d      = '0;
`endif
                state_d    = WAIT;
            end
            WAIT: begin
                if (ramBusy) begin
`ifdef MEM_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        error_d = 1'b1;
                        rdata_d = 32'h0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end else begin
                    if (!write_q) rdata_d[lane_lsb +: 8] = ramDataIn;
                    if (idx_q == last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                ram_we_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_we_q   <= ram_we_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Busy-wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign ready          = (state_q == IDLE);
    assign done           = (state_q == DONE);
    assign rdata          = rdata_q;
    assign ramAddr        = ram_addr_q;
    assign ramDataOut     = ram_dout_q;
    assign ramWriteEnable = ram_we_q;

endmodule
